rebble_spi_frame_writer: RTL and testbench
==========================================

# rebble_spi_frame_writer

MCU-facing SPI slave that sits directly upstream of the Rebble LCD driver. It decodes byte commands from the MCU, streams 6-bit RGB pixels into the shared frame-buffer RAM write port, issues the draw request to the LCD driver, and reports status and frame-done interrupts back to the MCU. Everything runs in the single master-clock domain; the SPI pins are oversampled.

## Interface
- `LINES`, 148: display rows.
- `COLUMNS`, 205: display columns.
- `ADDRW`, 15: frame-buffer address width; must satisfy LINES*COLUMNS ≤ 2^ADDRW.
- `clock`  in  1  master clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cs`  in  1  SPI chip select, active-low, asynchronous to `clock`.
- `sck`  in  1  SPI clock, mode 0, asynchronous.
- `mosi`  in  1  SPI data in, MSB first.
- `miso`  out  1  SPI data out; 0 whenever `cs` is high.
- `pixel_in`  out  6  pixel to RAM as {R[1:0],G[1:0],B[1:0]}.
- `pixel_waddr`  out  ADDRW  RAM write address.
- `pixel_write_en`  out  1  one-cycle write strobe.
- `draw`  out  1  one-cycle draw request to the LCD driver.
- `busy`  in  1  LCD driver frame in progress (synchronous to `clock`).
- `intn`  out  1  active-low frame-done interrupt.
- `reset_done`  out  1  high once the block is ready after reset.

## Operation
- Input sync: `cs`, `sck`, `mosi` each pass through a 2-flop synchronizer. Edges of `sck` and `cs` are detected on the synchronized copies.
- Shifting: bits are sampled on the synchronized `sck` rising edge, MSB first. A byte completes on the 8th rise. A `cs` rise abandons any partial byte and returns the FSM to IDLE.
- FSM states and transitions:
  - IDLE → CMD on a `cs` fall.
  - CMD decodes the first byte:
    - 0x01 → WRITE_PIX.
    - 0x02 → draw request, then DISCARD.
    - 0x03 → STATUS.
    - 0x04 → SET_ROW.
    - Any other value → DISCARD.
  - WRITE_PIX: each byte writes `pixel_in`=byte[5:0] to `pixel_waddr`, then the address increments. Bits [7:6] are ignored. After LINES*COLUMNS-1 the address wraps to 0 and sets status bit1 (overflow).
  - SET_ROW: the next byte r sets the address to r*COLUMNS, then → WRITE_PIX. If r ≥ LINES, the address is 0 and bit1 is set.
  - STATUS: shifts out the status byte, then 0x00 for any further bytes. Bits 0–2 clear at the end of that byte.
  - DISCARD: ignores bytes until `cs` rises.
- Address register: reset value 0. It persists across transactions, so a new 0x01 continues where the last one stopped.
- Draw (0x02):
  - If `busy`=0, pulse `draw` for one cycle and set an internal pending flag.
  - If `busy`=1, `draw` does not pulse and status bit2 (draw_rejected) is set.
- Status byte: bit0 = `busy` sampled at byte load, bit1 = overflow, bit2 = draw_rejected, bits7:3 = 0.
- Interrupt:
  - On a `busy` falling edge while pending: drive `intn` low and clear pending.
  - `intn` returns high on the next `cs` fall.
  - If the `busy` fall and the `cs` fall occur in the same cycle, the `cs` fall wins and `intn` is not asserted.
- `reset_done`: 0 in reset, then goes 1 16 cycles after `reset` deasserts and stays 1.

## Timing
- Reset values:
  - `miso`=0, `pixel_in`=0, `pixel_waddr`=0, `pixel_write_en`=0, `draw`=0, `intn`=1, `reset_done`=0.
  - FSM in IDLE; all status bits 0.
- SCK requirements: high and low phases each ≥ 4 `clock` periods. `cs` fall must precede the first `sck` rise by ≥ 4 periods.
- Write latency: `pixel_write_en` pulses exactly 3 cycles after the synchronized-domain sample of the 8th `sck` rise, i.e. 2 sync + 1 register.
- Address update: `pixel_waddr` increments on the cycle after the strobe and is stable until the next strobe.
- `draw` pulses 3 cycles after the last bit of the 0x02 byte.
- MISO in STATUS:
  - The status MSB is driven within 1 cycle of CMD-byte completion.
  - Subsequent bits change on synchronized `sck` falling edges.
  - Data is valid for ≥ 2 `clock` periods before the next `sck` rise at the minimum SCK rate.
- Asynchronous reset mid-transaction: all state is cleared immediately; the next transaction must start with a fresh `cs` fall.

## Structure
- Shared package `rebble_pkg`:
  - LINES, COLUMNS, ADDRW.
  - Command opcodes CMD_WRITE=8'h01, CMD_DRAW=8'h02, CMD_STATUS=8'h03, CMD_ROW=8'h04.
  - Status bit indices.
  - FSM state enum.
- Sub-module `spi_byte_rx`: synchronizers, edge detect, the 8-bit shift in/out registers, and `byte_valid`/`load_tx` handshakes.
- The top level holds the FSM, address counter, status, and interrupt logic.

## Test plan
- Reset, then wait 16 cycles → `reset_done` rises on cycle 16. All other outputs hold their reset values throughout.
- `cs` low, send 0x01, 0x2A, 0x15, `cs` high → writes 0x2A@0 and 0x15@1; `pixel_waddr` ends at 2.
- Send 0x04, 0x93, 0x3F → one write of 0x3F@30135 (147*205). Then send 30340-30135 bytes of 0x01 → address wraps to 0 and status bit1=1.
- With `busy`=0, send 0x02 → a single `draw` pulse. Raise then drop `busy` → `intn` goes 0; the next `cs` fall returns `intn` to 1.
- With `busy`=1, send 0x02 → no `draw`. Then send 0x03 → MISO reads 0x05; a second 0x03 with `busy`=0 reads 0x00.
- Raise `cs` after 5 bits of a pixel byte → no write. Send 0xFF → no writes while following bytes are clocked. Assert `reset` mid-byte → all outputs return to their reset values.

Source files
------------

// File: rtl/rebble_pkg.sv
// rtl/rebble_pkg.sv - shared geometry, opcodes, status bits and FSM states for the SPI frame writer
package rebble_pkg;

  localparam int LINES   = 148;
  localparam int COLUMNS = 205;
  localparam int ADDRW   = 15;
  localparam int NPIX    = LINES * COLUMNS;

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NPIX - 1);
  localparam logic [ADDRW-1:0] COLUMNS_W = ADDRW'(COLUMNS);
  localparam logic [7:0]       LINES_B   = 8'(LINES);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_DRAW   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_ROW    = 8'h04;

  localparam int ST_BUSY     = 0;
  localparam int ST_OVERFLOW = 1;
  localparam int ST_REJECTED = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE_PIX,
    S_SET_ROW,
    S_STATUS,
    S_DISCARD
  } state_t;

  // Caller guarantees r < LINES, so the product fits in ADDRW bits.
  function automatic logic [ADDRW-1:0] row_base(input logic [7:0] r);
    return ADDRW'(r) * COLUMNS_W;
  endfunction

endpackage

// File: rtl/rebble_spi_frame_writer_if.sv
// rtl/rebble_spi_frame_writer_if.sv - SPI pins, frame-buffer write port and LCD handshake bundle
interface rebble_spi_frame_writer_if;

  logic                        cs;
  logic                        sck;
  logic                        mosi;
  logic                        miso;
  logic [5:0]                  pixel_in;
  logic [rebble_pkg::ADDRW-1:0] pixel_waddr;
  logic                        pixel_write_en;
  logic                        draw;
  logic                        busy;
  logic                        intn;
  logic                        reset_done;

  modport master (
    output cs, sck, mosi, busy,
    input  miso, pixel_in, pixel_waddr, pixel_write_en, draw, intn, reset_done
  );

  modport slave (
    input  cs, sck, mosi, busy,
    output miso, pixel_in, pixel_waddr, pixel_write_en, draw, intn, reset_done
  );

endinterface

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - oversampled SPI mode-0 byte shifter with 2-flop pin synchronizers
module spi_byte_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  input  logic       load_tx,
  input  logic [7:0] tx_byte
);

  logic [2:0] cs_sync;
  logic [2:0] sck_sync;
  logic [1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic       cs_active;
  logic       sck_rise;
  logic       sck_fall;

  assign cs_active = ~cs_sync[1];
  assign cs_fall   = ~cs_sync[1] &  cs_sync[2];
  assign cs_rise   =  cs_sync[1] & ~cs_sync[2];
  assign sck_rise  =  sck_sync[1] & ~sck_sync[2];
  assign sck_fall  = ~sck_sync[1] &  sck_sync[2];
  assign rx_byte   = rx_shift;
  assign miso      = tx_shift[7] & ~cs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cs_sync    <= 3'b111;
      sck_sync   <= 3'b000;
      mosi_sync  <= 2'b00;
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      tx_shift   <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[1:0], cs};
      sck_sync   <= {sck_sync[1:0], sck};
      mosi_sync  <= {mosi_sync[0], mosi};
      byte_valid <= 1'b0;
      if (!cs_active) begin
        bit_cnt  <= 3'd0;
        tx_shift <= 8'h00;
      end else begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_sync[1]};
          bit_cnt  <= bit_cnt + 3'd1;
          // The master has taken the last bit on this rise; drain it so
          // later bytes read zero.
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            tx_shift   <= {tx_shift[6:0], 1'b0};
          end
        end else if (sck_fall && bit_cnt != 3'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
        if (load_tx) begin
          tx_shift <= tx_byte;
        end
      end
    end
  end

endmodule

// File: rtl/rebble_spi_frame_writer.sv
// rtl/rebble_spi_frame_writer.sv - MCU command decoder feeding the Rebble frame buffer and LCD driver
module rebble_spi_frame_writer
  import rebble_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  rebble_spi_frame_writer_if.slave    bus
);

  state_t     state;
  logic       cs_fall;
  logic       cs_rise;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       load_tx;
  logic [7:0] status_byte;
  logic       overflow;
  logic       rejected;
  logic       pending;
  logic       status_armed;
  logic       busy_q;
  logic [3:0] rst_cnt;

  assign status_byte = {5'b00000, rejected, overflow, bus.busy};
  // Loading in the decode cycle puts the status MSB on miso one cycle after byte completion.
  assign load_tx     = byte_valid && (state == S_CMD) && (rx_byte == CMD_STATUS);

  spi_byte_rx u_rx (
    .clock      (clock),
    .reset      (reset),
    .cs         (bus.cs),
    .sck        (bus.sck),
    .mosi       (bus.mosi),
    .miso       (bus.miso),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .load_tx    (load_tx),
    .tx_byte    (status_byte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      bus.pixel_in       <= 6'd0;
      bus.pixel_waddr    <= '0;
      bus.pixel_write_en <= 1'b0;
      bus.draw           <= 1'b0;
      bus.intn           <= 1'b1;
      bus.reset_done     <= 1'b0;
      rst_cnt            <= 4'd0;
      overflow           <= 1'b0;
      rejected           <= 1'b0;
      pending            <= 1'b0;
      status_armed       <= 1'b0;
      busy_q             <= 1'b0;
    end else begin
      busy_q             <= bus.busy;
      bus.pixel_write_en <= 1'b0;
      bus.draw           <= 1'b0;

      if (!bus.reset_done) begin
        rst_cnt <= rst_cnt + 4'd1;
        if (rst_cnt == 4'd15) bus.reset_done <= 1'b1;
      end

      if (bus.pixel_write_en) begin
        if (bus.pixel_waddr == LAST_ADDR) begin
          bus.pixel_waddr <= '0;
          overflow        <= 1'b1;
        end else begin
          bus.pixel_waddr <= bus.pixel_waddr + ADDRW'(1);
        end
      end

      // A cs fall in the same cycle as the busy fall suppresses the interrupt.
      if (cs_fall) begin
        bus.intn <= 1'b1;
      end else if (busy_q && !bus.busy && pending) begin
        bus.intn <= 1'b0;
        pending  <= 1'b0;
      end

      if (cs_rise) begin
        state        <= S_IDLE;
        status_armed <= 1'b0;
      end else if (cs_fall && state == S_IDLE) begin
        state <= S_CMD;
      end else if (byte_valid) begin
        case (state)
          S_CMD: begin
            case (rx_byte)
              CMD_WRITE: state <= S_WRITE_PIX;
              CMD_DRAW: begin
                state <= S_DISCARD;
                if (bus.busy) begin
                  rejected <= 1'b1;
                end else begin
                  bus.draw <= 1'b1;
                  pending  <= 1'b1;
                end
              end
              CMD_STATUS: begin
                state        <= S_STATUS;
                status_armed <= 1'b1;
              end
              CMD_ROW: state <= S_SET_ROW;
              default: state <= S_DISCARD;
            endcase
          end
          S_WRITE_PIX: begin
            bus.pixel_write_en <= 1'b1;
            bus.pixel_in       <= rx_byte[5:0];
          end
          S_SET_ROW: begin
            state <= S_WRITE_PIX;
            if (rx_byte < LINES_B) begin
              bus.pixel_waddr <= row_base(rx_byte);
            end else begin
              bus.pixel_waddr <= '0;
              overflow        <= 1'b1;
            end
          end
          S_STATUS: begin
            if (status_armed) begin
              status_armed <= 1'b0;
              overflow     <= 1'b0;
              rejected     <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rebble_spi_frame_writer.sv
// tb/tb_rebble_spi_frame_writer.sv - directed SPI command sequences with hand-computed expectations
module tb_rebble_spi_frame_writer;
  import rebble_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  rebble_spi_frame_writer_if bus ();

  rebble_spi_frame_writer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int n_draws     = 0;
  logic [ADDRW-1:0] w_addr [$];
  logic [5:0]       w_data [$];

  always @(negedge clock) begin
    if (bus.pixel_write_en === 1'b1) begin
      w_addr.push_back(bus.pixel_waddr);
      w_data.push_back(bus.pixel_in);
    end
    if (bus.draw === 1'b1) n_draws++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(6);
    bus.cs = 1'b1;
    tick(8);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.mosi = tx[i];
      tick(5);
      rx = {rx[6:0], bus.miso};
      bus.sck = 1'b1;
      tick(5);
      bus.sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] dummy;
    xfer(tx, 8, dummy);
  endtask

  initial begin
    logic [7:0] rx;
    int         nw;

    bus.cs   = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    bus.busy = 1'b0;
    tick(3);
    check("rst_miso", 32'(bus.miso), 0);
    check("rst_pixel_in", 32'(bus.pixel_in), 0);
    check("rst_waddr", 32'(bus.pixel_waddr), 0);
    check("rst_we", 32'(bus.pixel_write_en), 0);
    check("rst_draw", 32'(bus.draw), 0);
    check("rst_intn", 32'(bus.intn), 1);
    check("rst_done_in_reset", 32'(bus.reset_done), 0);

    reset = 1'b1;
    tick(15);
    check("reset_done_cycle15", 32'(bus.reset_done), 0);
    tick(1);
    check("reset_done_cycle16", 32'(bus.reset_done), 1);
    tick(4);
    check("idle_no_writes", 32'(w_addr.size()), 0);
    check("idle_no_draws", 32'(n_draws), 0);
    check("idle_intn", 32'(bus.intn), 1);

    // Two pixels from address 0
    cs_low(); send(8'h01); send(8'h2A); send(8'h15); cs_high();
    check("wr_count", 32'(w_addr.size()), 2);
    check("wr0_addr", 32'(w_addr[0]), 0);
    check("wr0_data", 32'(w_data[0]), 32'h2A);
    check("wr1_addr", 32'(w_addr[1]), 1);
    check("wr1_data", 32'(w_data[1]), 32'h15);
    check("wr_end_addr", 32'(bus.pixel_waddr), 2);

    // Last row then wrap: 147*205 = 30135, upper byte bits ignored
    cs_low(); send(8'h04); send(8'h93); send(8'hFF); cs_high();
    check("row_count", 32'(w_addr.size()), 3);
    check("row_addr", 32'(w_addr[2]), 30135);
    check("row_data", 32'(w_data[2]), 32'h3F);
    check("row_next_addr", 32'(bus.pixel_waddr), 30136);

    cs_low(); send(8'h01);
    repeat (204) send(8'h01);
    cs_high();
    check("wrap_count", 32'(w_addr.size()), 207);
    check("wrap_last_addr", 32'(w_addr[206]), 30339);
    check("wrap_addr", 32'(bus.pixel_waddr), 0);

    cs_low(); xfer(8'h03, 8, rx);
    check("status_cmd_miso", 32'(rx), 0);
    xfer(8'h00, 8, rx);
    check("status_overflow", 32'(rx), 32'h02);
    xfer(8'h00, 8, rx);
    check("status_trailing", 32'(rx), 32'h00);
    cs_high();

    // Row 1 base = 205; row 200 is out of range
    cs_low(); send(8'h04); send(8'h01); send(8'h07); cs_high();
    check("row1_addr", 32'(w_addr[207]), 205);
    check("row1_data", 32'(w_data[207]), 32'h07);
    check("row1_next", 32'(bus.pixel_waddr), 206);
    cs_low(); send(8'h04); send(8'hC8); cs_high();
    check("badrow_addr", 32'(bus.pixel_waddr), 0);
    check("badrow_no_write", 32'(w_addr.size()), 208);
    cs_low(); send(8'h03); xfer(8'h00, 8, rx); cs_high();
    check("badrow_status", 32'(rx), 32'h02);

    // Accepted draw and frame-done interrupt
    bus.busy = 1'b0;
    cs_low(); send(8'h02); cs_high();
    check("draw_single_pulse", 32'(n_draws), 1);
    bus.busy = 1'b1;
    tick(4);
    check("intn_during_busy", 32'(bus.intn), 1);
    bus.busy = 1'b0;
    tick(3);
    check("intn_frame_done", 32'(bus.intn), 0);
    bus.busy = 1'b1;
    tick(2);
    cs_low();
    check("intn_cleared_by_cs", 32'(bus.intn), 1);

    // Rejected draw while busy
    send(8'h02); cs_high();
    check("draw_rejected", 32'(n_draws), 1);
    cs_low(); send(8'h03); xfer(8'h00, 8, rx); cs_high();
    check("status_busy_rej", 32'(rx), 32'h05);
    bus.busy = 1'b0;
    tick(3);
    check("intn_no_pending", 32'(bus.intn), 1);
    cs_low(); send(8'h03); xfer(8'h00, 8, rx); cs_high();
    check("status_cleared", 32'(rx), 32'h00);

    // Partial byte abandoned by cs rise
    nw = w_addr.size();
    cs_low(); send(8'h01); xfer(8'h2A, 5, rx); cs_high();
    check("partial_no_write", 32'(w_addr.size()), 32'(nw));
    check("partial_addr", 32'(bus.pixel_waddr), 0);

    cs_low(); send(8'hFF); send(8'h11); send(8'h22); cs_high();
    check("discard_no_write", 32'(w_addr.size()), 32'(nw));
    check("discard_no_draw", 32'(n_draws), 1);
    check("miso_cs_high", 32'(bus.miso), 0);

    // Asynchronous reset mid-byte
    cs_low(); send(8'h01); send(8'h15); xfer(8'h3A, 4, rx);
    check("pre_reset_addr", 32'(bus.pixel_waddr), 1);
    check("pre_reset_pixel", 32'(bus.pixel_in), 32'h15);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_waddr", 32'(bus.pixel_waddr), 0);
    check("midrst_pixel_in", 32'(bus.pixel_in), 0);
    check("midrst_we", 32'(bus.pixel_write_en), 0);
    check("midrst_draw", 32'(bus.draw), 0);
    check("midrst_intn", 32'(bus.intn), 1);
    check("midrst_miso", 32'(bus.miso), 0);
    check("midrst_done", 32'(bus.reset_done), 0);
    bus.cs  = 1'b1;
    bus.sck = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(20);
    check("post_reset_done", 32'(bus.reset_done), 1);
    check("post_reset_addr", 32'(bus.pixel_waddr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
